// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jump, call/return and a circular return-address stack.
// Sticky ovf/unf flags record calls on a full stack and returns on an empty one.
module pc_sequencer #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       br,
  input  logic                       call,
  input  logic                       ret,
  input  logic [AW-1:0]              target,
  input  logic                       clr_err,
  output logic [AW-1:0]              pc,
  output logic [$clog2(DEPTH+1)-1:0] ras_cnt,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] ras_mem [DEPTH];
  logic [PW-1:0] wr_ptr;

  logic [AW-1:0] pc_inc_c;
  logic [PW-1:0] rd_ptr_c;
  logic [AW-1:0] pc_nxt_c;
  logic [CW-1:0] cnt_nxt_c;
  logic [PW-1:0] ptr_nxt_c;
  logic          push_c;
  logic          ovf_set_c;
  logic          unf_set_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
  endfunction

  assign pc_inc_c = pc + AW'(1);
  assign rd_ptr_c = ptr_dec(wr_ptr);

  // Action select: ret > call > br > sequential; wr_ptr names the next free slot.
  always_comb begin
    pc_nxt_c  = pc;
    cnt_nxt_c = ras_cnt;
    ptr_nxt_c = wr_ptr;
    push_c    = 1'b0;
    ovf_set_c = 1'b0;
    unf_set_c = 1'b0;
    if (en) begin
      if (ret) begin
        if (ras_cnt != '0) begin
          pc_nxt_c  = ras_mem[rd_ptr_c];
          cnt_nxt_c = ras_cnt - CW'(1);
          ptr_nxt_c = rd_ptr_c;
        end else begin
          pc_nxt_c  = pc_inc_c;
          unf_set_c = 1'b1;
        end
      end else if (call) begin
        push_c    = 1'b1;
        pc_nxt_c  = target;
        ptr_nxt_c = ptr_inc(wr_ptr);
        // A full stack overwrites its oldest entry, which sits at the write slot.
        if (ras_cnt == CW'(DEPTH)) ovf_set_c = 1'b1;
        else                       cnt_nxt_c = ras_cnt + CW'(1);
      end else if (br) begin
        pc_nxt_c = target;
      end else begin
        pc_nxt_c = pc_inc_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ras_cnt <= '0;
      wr_ptr  <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      pc      <= pc_nxt_c;
      ras_cnt <= cnt_nxt_c;
      wr_ptr  <= ptr_nxt_c;
      ovf     <= ovf_set_c | (ovf & ~clr_err);
      unf     <= unf_set_c | (unf & ~clr_err);
    end
  end

  // Entry storage is not reset; a push sampled during reset is dropped.
  always_ff @(posedge clk) begin
    if (push_c && !rst) ras_mem[wr_ptr] <= pc_inc_c;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences
// for overflow/underflow/async reset, and random stimulus against a queue model.
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, br = 1'b0, call = 1'b0, ret = 1'b0, clr_err = 1'b0;
  logic [7:0] target = '0;
  logic [7:0] pc;
  logic [2:0] ras_cnt;
  logic       ovf, unf;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers and a queue used as the return stack.
  int unsigned m_pc;
  int unsigned m_q[$];
  bit          m_ovf, m_unf;

  typedef struct {
    logic       en, br, call, ret, clr;
    logic [7:0] tgt;
    logic [7:0] epc;
    logic [2:0] ecnt;
    logic       eovf, eunf;
  } vec_t;

  vec_t vecs[17];

  pc_sequencer #(.AW(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .br(br), .call(call), .ret(ret),
    .target(target), .clr_err(clr_err),
    .pc(pc), .ras_cnt(ras_cnt), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input bit e, input bit b, input bit c, input bit r,
                            input int unsigned t, input bit cl);
    bit so = 0, su = 0;
    if (e) begin
      if (r) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin m_pc = (m_pc + 1) % 256; su = 1; end
      end else if (c) begin
        m_q.push_back((m_pc + 1) % 256);
        if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); so = 1; end
        m_pc = t;
      end else if (b) m_pc = t;
      else m_pc = (m_pc + 1) % 256;
    end
    m_ovf = so | (m_ovf & !cl);
    m_unf = su | (m_unf & !cl);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".pc"},  int'(pc),      int'(m_pc));
    chk({tag, ".cnt"}, int'(ras_cnt), int'(m_q.size()));
    chk({tag, ".ovf"}, int'(ovf),     int'(m_ovf));
    chk({tag, ".unf"}, int'(unf),     int'(m_unf));
  endtask

  // Drive at negedge, advance one rising edge, sample 1ns later.
  task automatic step(input bit e, input bit b, input bit c, input bit r,
                      input logic [7:0] t, input bit cl, input string tag);
    @(negedge clk);
    en = e; br = b; call = c; ret = r; target = t; clr_err = cl;
    @(posedge clk);
    model_step(e, b, c, r, int'(t), cl);
    #1;
    cmp_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 0; br = 0; call = 0; ret = 0; clr_err = 0;
    #2;
    model_reset();
    cmp_model("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //            en br ca re cl tgt    pc     cnt  ovf unf
    vecs[0]  = '{1, 0, 0, 0, 0, 8'h00, 8'h01, 3'd0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 8'h00, 8'h02, 3'd0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 8'h00, 8'h03, 3'd0, 0, 0};
    vecs[3]  = '{1, 1, 0, 0, 0, 8'd10, 8'd10, 3'd0, 0, 0};
    vecs[4]  = '{1, 0, 1, 0, 0, 8'd40, 8'd40, 3'd1, 0, 0};
    vecs[5]  = '{1, 0, 1, 0, 0, 8'd80, 8'd80, 3'd2, 0, 0};
    vecs[6]  = '{1, 0, 0, 1, 0, 8'd00, 8'd41, 3'd1, 0, 0};
    vecs[7]  = '{1, 0, 0, 1, 0, 8'd00, 8'd11, 3'd0, 0, 0};
    vecs[8]  = '{1, 1, 0, 0, 0, 8'd49, 8'd49, 3'd0, 0, 0};
    vecs[9]  = '{1, 0, 1, 0, 0, 8'd07, 8'd07, 3'd1, 0, 0};
    vecs[10] = '{1, 1, 1, 1, 0, 8'd99, 8'd50, 3'd0, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 0, 8'd33, 8'd50, 3'd0, 0, 0};
    vecs[12] = '{1, 1, 0, 0, 0, 8'hFF, 8'hFF, 3'd0, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0};
    vecs[14] = '{1, 0, 0, 1, 0, 8'h00, 8'h01, 3'd0, 0, 1};
    vecs[15] = '{1, 0, 0, 1, 1, 8'h00, 8'h02, 3'd0, 0, 1};
    vecs[16] = '{0, 0, 0, 0, 1, 8'h00, 8'h02, 3'd0, 0, 0};

    // Initial reset, checked before any clock edge.
    #2;
    model_reset();
    cmp_model("por");
    do_reset();

    // Directed table: sequence, wrap, call/ret nesting, priority, stall, flag clear.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].en, vecs[i].br, vecs[i].call, vecs[i].ret, vecs[i].tgt, vecs[i].clr,
           $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.pc", i),  int'(pc),      int'(vecs[i].epc));
      chk($sformatf("vec%0d.cnt", i), int'(ras_cnt), int'(vecs[i].ecnt));
      chk($sformatf("vec%0d.ovf", i), int'(ovf),     int'(vecs[i].eovf));
      chk($sformatf("vec%0d.unf", i), int'(unf),     int'(vecs[i].eunf));
    end

    // Overflow: five calls from pc 1..5, each to the following address.
    do_reset();
    step(1, 1, 0, 0, 8'd1, 0, "ov.br");
    for (int i = 1; i <= 5; i++) step(1, 0, 1, 0, 8'(i + 1), 0, "ov.call");
    chk("ov.cnt", int'(ras_cnt), 4);
    chk("ov.flag", int'(ovf), 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 8'h00, 0, "ov.ret");
      chk("ov.retpc", int'(pc), 6 - i);
    end
    step(1, 0, 0, 1, 8'h00, 0, "ov.ret5");
    chk("ov.unf", int'(unf), 1);
    chk("ov.unfpc", int'(pc), 4);
    step(0, 0, 0, 0, 8'h00, 1, "ov.clr");
    chk("ov.clr_ovf", int'(ovf), 0);
    chk("ov.clr_unf", int'(unf), 0);

    // Async reset between edges after two calls.
    do_reset();
    step(1, 0, 1, 0, 8'd20, 0, "ar.call1");
    step(1, 0, 1, 0, 8'd30, 0, "ar.call2");
    @(negedge clk);
    en = 0; call = 0;
    #1 rst = 1'b1;
    #1;
    chk("ar.pc", int'(pc), 0);
    chk("ar.cnt", int'(ras_cnt), 0);
    model_reset();
    // A call presented while reset is held must leave no trace.
    en = 1; call = 1; target = 8'd77;
    @(posedge clk); #1;
    chk("ar.hold_pc", int'(pc), 0);
    chk("ar.hold_cnt", int'(ras_cnt), 0);
    @(negedge clk);
    rst = 1'b0; en = 0; call = 0;
    step(1, 0, 0, 1, 8'h00, 0, "ar.ret");
    chk("ar.ret_unf", int'(unf), 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           8'($urandom), $urandom_range(0, 9) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter AW, default 8, meaning program-counter and target address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of return-address stack (RAS) entries; legal range 2..16.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  advance enable; low = stall.
REQ-006 SHALL have port br  input  1  unconditional jump request to target.
REQ-007 SHALL have port call  input  1  subroutine call request: push return address, jump to target.
REQ-008 SHALL have port ret  input  1  subroutine return request: pop RAS into pc.
REQ-009 SHALL have port target  input  AW  jump/call destination address.
REQ-010 SHALL have port clr_err  input  1  synchronous clear of ovf and unf.
REQ-011 SHALL have port pc  output  AW  current program counter, registered.
REQ-012 SHALL have port ras_cnt  output  $clog2(DEPTH+1)  number of valid RAS entries, registered.
REQ-013 SHALL have port ovf  output  1  sticky flag: call issued with RAS full.
REQ-014 SHALL have port unf  output  1  sticky flag: ret issued with RAS empty.

Function
REQ-015 SHALL, when en=0, hold pc, RAS contents, ras_cnt, ovf and unf unchanged, except clr_err, which SHALL still act.
REQ-016 SHALL, when en=1, select one action per cycle with priority ret > call > br > sequential; lower-priority requests that cycle SHALL be ignored.
REQ-017 SHALL, on sequential action, set pc to pc+1 modulo 2^AW (all-ones wraps to 0).
REQ-018 SHALL, on br, set pc to target next cycle; RAS untouched.
REQ-019 SHALL, on call with ras_cnt<DEPTH, push (pc+1) mod 2^AW onto RAS, increment ras_cnt, and set pc to target.
REQ-020 SHALL, on call with ras_cnt=DEPTH, discard the oldest entry, push (pc+1) mod 2^AW as newest, keep ras_cnt=DEPTH, set ovf, and set pc to target.
REQ-021 SHALL, on ret with ras_cnt>0, set pc to the newest RAS entry and decrement ras_cnt (LIFO order).
REQ-022 SHALL, on ret with ras_cnt=0, set pc to pc+1 mod 2^AW, leave ras_cnt at 0, and set unf.
REQ-023 SHALL treat ovf and unf as sticky until rst or clr_err; if clr_err and a setting event coincide, the flag SHALL be 1 after the edge.
REQ-024 SHALL update pc with single-cycle latency: effect of a request sampled at edge N is visible on pc after edge N.
REQ-025 SHALL have no combinational path from any input to any output.
REQ-026 SHALL implement the RAS as a circular buffer with a top pointer; entry storage need not be reset.

Reset
REQ-027 SHALL, while rst=1, force pc=0, ras_cnt=0, ovf=0, unf=0 asynchronously, independent of clk.
REQ-028 SHALL, on rst deassertion, resume sequential behaviour at the first rising clk edge with en=1; entries pushed before reset are unreachable (ras_cnt=0).
REQ-029 SHALL, on rst asserted mid-call or mid-ret, discard that request completely.

Verification (AW=8, DEPTH=4)
REQ-030 SHALL verify reset/sequence: pulse rst, then en=1 for 3 cycles -> pc 0,1,2,3; ras_cnt=0; flags 0; with pc=8'hFF one more cycle -> pc=8'h00.
REQ-031 SHALL verify call/ret nesting: at pc=10 call target=40, at pc=40 call target=80, then ret, ret -> pc 40, 80, 41, 11; ras_cnt 1,2,1,0.
REQ-032 SHALL verify overflow: 5 calls from pc=1,2,3,4,5 (each target=pc+1 of preceding call) -> ras_cnt=4, ovf=1; four rets return 6,5,4,3; fifth ret -> unf=1, pc increments.
REQ-033 SHALL verify priority/stall: ret+call+br together with RAS holding 50 -> pc=50, ras_cnt decremented; en=0 with call asserted -> pc and ras_cnt unchanged.
REQ-034 SHALL verify flag clear: ovf=1, assert clr_err one cycle -> ovf=0; clr_err coincident with empty ret -> unf=1.
REQ-035 SHALL verify async reset: assert rst between clock edges after two calls -> pc=0, ras_cnt=0 immediately, before next edge.
